clint_timer_pipe_ctrl: RTL and testbench



---
 rtl/clint_timer_pipe_ctrl.sv | 109 ++++++++++
 tb/tb_clint_timer_pipe_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clint_timer_pipe_ctrl.sv
// clint_timer_pipe_ctrl: CLINT machine timer (mtime/mtimecmp) plus pipeline stall/flush controller.
// Ports:
//   clk, rst (sync, active-low)
//   mtime_addr_i / mtime_write_valid_i / mtime_wdata_i : 32-bit word write bus
//   mtime_rdata_o    : combinational read data, 0 for unmapped addresses
//   mtime_ge_mtime_o : mtime >= mtimecmp (unsigned 64-bit)
//   hazard inputs    : per-stage requests from fetch, decode, execute, memory, trap
//   stall_o, flush_o : per-stage freeze/bubble, bit0 PC .. bit5 WB
module clint_timer_pipe_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mtime_addr_i,
    input  logic        mtime_write_valid_i,
    input  logic [31:0] mtime_wdata_i,
    output logic [31:0] mtime_rdata_o,
    output logic        mtime_ge_mtime_o,
    input  logic        compress_stall,
    input  logic        if_rdata_valid_i,
    input  logic        ls_valid_i,
    input  logic        ram_stall_valid_if_i,
    input  logic        ram_stall_valid_mem_i,
    input  logic        load_use_valid_id_i,
    input  logic        jump_valid_ex_i,
    input  logic        alu_mul_div_valid_ex_i,
    input  logic        trap_flush_valid_wb_i,
    input  logic        trap_stall_valid_wb_i,
    output logic [5:0]  stall_o,
    output logic [5:0]  flush_o
);

    localparam logic [31:0] CMP_LO  = BASE_ADDR + 32'h4000;
    localparam logic [31:0] CMP_HI  = BASE_ADDR + 32'h4004;
    localparam logic [31:0] TIME_LO = BASE_ADDR + 32'hBFF8;
    localparam logic [31:0] TIME_HI = BASE_ADDR + 32'hBFFC;
    localparam logic [31:0] DIV_TOP = 32'(TICK_DIV - 1);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] div_q, div_d;
    logic        tick;
    logic        wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi;

    always_comb begin
        tick       = (div_q == DIV_TOP);
        div_d      = tick ? 32'd0 : div_q + 32'd1;
        wr_time_lo = mtime_write_valid_i && (mtime_addr_i == TIME_LO);
        wr_time_hi = mtime_write_valid_i && (mtime_addr_i == TIME_HI);
        wr_cmp_lo  = mtime_write_valid_i && (mtime_addr_i == CMP_LO);
        wr_cmp_hi  = mtime_write_valid_i && (mtime_addr_i == CMP_HI);
        // A bus write to either half of mtime replaces this cycle's increment.
        mtime_d    = wr_time_lo ? {mtime_q[63:32], mtime_wdata_i} :
                     wr_time_hi ? {mtime_wdata_i, mtime_q[31:0]} :
                     tick       ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = wr_cmp_lo ? {mtimecmp_q[63:32], mtime_wdata_i} :
                     wr_cmp_hi ? {mtime_wdata_i, mtimecmp_q[31:0]} : mtimecmp_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            div_q      <= 32'd0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            div_q      <= div_d;
        end
    end

    always_comb begin
        mtime_rdata_o    = (mtime_addr_i == CMP_LO)  ? mtimecmp_q[31:0]  :
                           (mtime_addr_i == CMP_HI)  ? mtimecmp_q[63:32] :
                           (mtime_addr_i == TIME_LO) ? mtime_q[31:0]     :
                           (mtime_addr_i == TIME_HI) ? mtime_q[63:32]    : 32'd0;
        mtime_ge_mtime_o = (mtime_q >= mtimecmp_q);
    end

    // An if/else chain keeps lower-priority inputs from influencing the
    // result once a higher-priority request has matched.
    always_comb begin
        stall_o = 6'b000000;
        flush_o = 6'b000000;
        if (!rst) begin
            flush_o = 6'b111111;
        end else if (trap_stall_valid_wb_i) begin
            stall_o = 6'b111111;
        end else if (trap_flush_valid_wb_i) begin
            flush_o = 6'b011110;
        end else if (ram_stall_valid_mem_i || ls_valid_i) begin
            stall_o = 6'b011111;
            flush_o = 6'b100000;
        end else if (alu_mul_div_valid_ex_i) begin
            stall_o = 6'b001111;
            flush_o = 6'b010000;
        end else if (jump_valid_ex_i) begin
            flush_o = 6'b000110;
        end else if (load_use_valid_id_i) begin
            stall_o = 6'b000111;
            flush_o = 6'b001000;
        end else if (ram_stall_valid_if_i || !if_rdata_valid_i || compress_stall) begin
            stall_o = 6'b000011;
            flush_o = 6'b000100;
        end
    end

endmodule

// File: tb/tb_clint_timer_pipe_ctrl.sv
// tb_clint_timer_pipe_ctrl: directed-vector bench for the CLINT timer and pipeline controller.
module tb_clint_timer_pipe_ctrl;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mtime_addr_i;
    logic        mtime_write_valid_i;
    logic [31:0] mtime_wdata_i;
    logic [31:0] mtime_rdata_o;
    logic        mtime_ge_mtime_o;
    logic        compress_stall, if_rdata_valid_i, ls_valid_i, ram_stall_valid_if_i;
    logic        ram_stall_valid_mem_i, load_use_valid_id_i, jump_valid_ex_i;
    logic        alu_mul_div_valid_ex_i, trap_flush_valid_wb_i, trap_stall_valid_wb_i;
    logic [5:0]  stall_o, flush_o;

    int n_vec = 0;
    int n_err = 0;

    clint_timer_pipe_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst),
        .mtime_addr_i(mtime_addr_i), .mtime_write_valid_i(mtime_write_valid_i),
        .mtime_wdata_i(mtime_wdata_i), .mtime_rdata_o(mtime_rdata_o),
        .mtime_ge_mtime_o(mtime_ge_mtime_o),
        .compress_stall(compress_stall), .if_rdata_valid_i(if_rdata_valid_i),
        .ls_valid_i(ls_valid_i), .ram_stall_valid_if_i(ram_stall_valid_if_i),
        .ram_stall_valid_mem_i(ram_stall_valid_mem_i),
        .load_use_valid_id_i(load_use_valid_id_i), .jump_valid_ex_i(jump_valid_ex_i),
        .alu_mul_div_valid_ex_i(alu_mul_div_valid_ex_i),
        .trap_flush_valid_wb_i(trap_flush_valid_wb_i),
        .trap_stall_valid_wb_i(trap_stall_valid_wb_i),
        .stall_o(stall_o), .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        mtime_addr_i = BASE + off;
        #1;
        check(tag, {32'd0, mtime_rdata_o}, {32'd0, exp});
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        mtime_addr_i        = BASE + off;
        mtime_wdata_i       = data;
        mtime_write_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mtime_write_valid_i = 1'b0;
    endtask

    // v bits: 0 trap_stall, 1 trap_flush, 2 ram_mem, 3 ls, 4 muldiv,
    //         5 jump, 6 load_use, 7 ram_if, 8 if_valid, 9 compress
    task automatic hz(input string tag, input logic [9:0] v, input logic [5:0] es, input logic [5:0] ef);
        trap_stall_valid_wb_i  = v[0];
        trap_flush_valid_wb_i  = v[1];
        ram_stall_valid_mem_i  = v[2];
        ls_valid_i             = v[3];
        alu_mul_div_valid_ex_i = v[4];
        jump_valid_ex_i        = v[5];
        load_use_valid_id_i    = v[6];
        ram_stall_valid_if_i   = v[7];
        if_rdata_valid_i       = v[8];
        compress_stall         = v[9];
        #1;
        check({tag, "_stall"}, {58'd0, stall_o}, {58'd0, es});
        check({tag, "_flush"}, {58'd0, flush_o}, {58'd0, ef});
    endtask

    initial begin
        rst = 1'b0;
        mtime_addr_i = BASE + 32'hBFF8;
        mtime_write_valid_i = 1'b0;
        mtime_wdata_i = 32'd0;
        {compress_stall, ls_valid_i, ram_stall_valid_if_i, ram_stall_valid_mem_i,
         load_use_valid_id_i, jump_valid_ex_i, alu_mul_div_valid_ex_i,
         trap_flush_valid_wb_i, trap_stall_valid_wb_i} = '0;
        if_rdata_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd("rst_mtime", 32'hBFF8, 32'd0);
        check("rst_flag", {63'd0, mtime_ge_mtime_o}, 64'd0);
        check("rst_flush", {58'd0, flush_o}, 64'h3F);
        check("rst_stall", {58'd0, stall_o}, 64'h0);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rd("idle10_lo", 32'hBFF8, 32'd10);
        rd("idle10_hi", 32'hBFFC, 32'd0);
        rd("cmp_lo_rst", 32'h4000, 32'hFFFF_FFFF);
        rd("cmp_hi_rst", 32'h4004, 32'hFFFF_FFFF);
        check("flag_idle", {63'd0, mtime_ge_mtime_o}, 64'd0);
        wr(32'h4000, 32'd20);
        wr(32'h4004, 32'd0);
        rd("cmp_lo_20", 32'h4000, 32'd20);
        rd("mtime_12", 32'hBFF8, 32'd12);
        check("flag_12", {63'd0, mtime_ge_mtime_o}, 64'd0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rd("mtime_19", 32'hBFF8, 32'd19);
        check("flag_19", {63'd0, mtime_ge_mtime_o}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rd("mtime_20", 32'hBFF8, 32'd20);
        check("flag_20", {63'd0, mtime_ge_mtime_o}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("flag_22", {63'd0, mtime_ge_mtime_o}, 64'd1);
        wr(32'h4004, 32'd1);
        check("flag_cmphi", {63'd0, mtime_ge_mtime_o}, 64'd0);
        rd("mtime_23", 32'hBFF8, 32'd23);
        wr(32'hBFF8, 32'hFFFF_FFFF);
        rd("wlo_hi_kept", 32'hBFFC, 32'd0);
        wr(32'hBFFC, 32'hFFFF_FFFF);
        rd("max_lo", 32'hBFF8, 32'hFFFF_FFFF);
        rd("max_hi", 32'hBFFC, 32'hFFFF_FFFF);
        check("flag_max", {63'd0, mtime_ge_mtime_o}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        rd("wrap_lo", 32'hBFF8, 32'd0);
        rd("wrap_hi", 32'hBFFC, 32'd0);
        check("flag_wrap", {63'd0, mtime_ge_mtime_o}, 64'd0);
        rd("unmapped_rd", 32'h8000, 32'd0);
        wr(32'h8000, 32'd5);
        rd("unmapped_wr", 32'hBFF8, 32'd1);
        rd("cmp_lo_kept", 32'h4000, 32'd20);
        hz("all_hz",     10'b10_1111_1111, 6'h3F, 6'h00);
        hz("trap_flush", 10'b10_1111_1110, 6'h00, 6'h1E);
        hz("mem_all",    10'b10_1111_1100, 6'h1F, 6'h20);
        hz("ls_only",    10'b01_0000_1000, 6'h1F, 6'h20);
        hz("ram_mem",    10'b01_0000_0100, 6'h1F, 6'h20);
        hz("muldiv",     10'b01_0001_0000, 6'h0F, 6'h10);
        hz("jump_lu",    10'b01_0110_0000, 6'h00, 6'h06);
        hz("load_use",   10'b01_0100_0000, 6'h07, 6'h08);
        hz("ram_if",     10'b01_1000_0000, 6'h03, 6'h04);
        hz("if_invalid", 10'b00_0000_0000, 6'h03, 6'h04);
        hz("idle",       10'b01_0000_0000, 6'h00, 6'h00);
        hz("compress",   10'b11_0000_0000, 6'h03, 6'h04);
        {ls_valid_i, ram_stall_valid_if_i, ram_stall_valid_mem_i, load_use_valid_id_i,
         jump_valid_ex_i, alu_mul_div_valid_ex_i, trap_flush_valid_wb_i} = 'x;
        trap_stall_valid_wb_i = 1'b1;
        #1;
        check("x_lower_stall", {58'd0, stall_o}, 64'h3F);
        check("x_lower_flush", {58'd0, flush_o}, 64'h00);
        hz("compress2",  10'b11_0000_0000, 6'h03, 6'h04);
        rst = 1'b0;
        #1;
        check("midrst_flush", {58'd0, flush_o}, 64'h3F);
        check("midrst_stall", {58'd0, stall_o}, 64'h00);
        @(posedge clk);
        @(negedge clk);
        rd("midrst_mtime", 32'hBFF8, 32'd0);
        rd("midrst_cmp", 32'h4000, 32'hFFFF_FFFF);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd("post_rst_3", 32'hBFF8, 32'd3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
